data_selector: RTL and testbench
================================

DATA_SELECTOR -- requirements
Module: data_selector

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 4: bits per selectable item (nibble).
REQ-002 SHALL have parameter MAIN_INPUTS, default 16: number of items in wData.
REQ-003 SHALL have parameter REGS_INPUTS, default 64: number of items across wRegs0..wRegs7.
REQ-004 SHALL have parameter REGS_BITS_PER_INPUT, default 32: width of each wRegsN port.
REQ-005 SHALL have parameter SELECTOR_OUTPUTS, default 4: items per data_out word.
REQ-006 SHALL have parameter SELECTOR_OUTPUTS_PER_BUS, default 4: number of groups serialized onto data_out.
REQ-007 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-008 SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-009 SHALL have port wBusy, input, 1 bit: stall; when high, all state holds.
REQ-010 SHALL have port wSelec, input, 176 bits: 16 selector slots of 11 bits; slot s = wSelec[11s+10:11s] = {regs_sel[5:0], main_sel[3:0], origin}.
REQ-011 SHALL have port wData, input, 64 bits: main item k = wData[4k+3:4k], k = 0..15.
REQ-012 SHALL have ports wRegs0..wRegs7, input, 32 bits each: register bank R = {wRegs7,...,wRegs0}; reg item r = R[4r+3:4r], r = 0..63, so wRegs0[3:0] is item 0.
REQ-013 SHALL have port data_out, output, 16 bits: registered result word.

Function
REQ-014 SHALL resolve item(s) per slot: origin=0 -> main item main_sel; origin=1 -> reg item regs_sel; the unused select field is ignored.
REQ-015 SHALL keep a 2-bit group counter g (0..3); group g covers slots 4g..4g+3.
REQ-016 SHALL form word(g) = {item(4g+3), item(4g+2), item(4g+1), item(4g)}; slot 4g occupies data_out[3:0].
REQ-017 On a rising edge with rst=1 and wBusy=0: data_out <= word(g) built from the input values present at that edge, and g <= g+1 modulo 4 (3 wraps to 0).
REQ-018 On a rising edge with rst=1 and wBusy=1: data_out and g SHALL hold; inputs are ignored.
REQ-019 Latency SHALL be one clock: an input or select change is visible on data_out after the first unstalled edge that samples the group containing it.
REQ-020 Selection logic SHALL be purely combinational from inputs to the data_out register; no other pipeline stages.
REQ-021 All select codes SHALL be legal at default parameters (4-bit main_sel covers 16 items, 6-bit regs_sel covers 64 items); no error output.
REQ-022 Slots may select the same item; duplicates SHALL be allowed.

Reset
REQ-023 On a rising edge with rst=0: data_out <= 16'h0000 and g <= 0, regardless of wBusy or other inputs.
REQ-024 Reset asserted mid-sequence SHALL abort the current rotation; the first unstalled edge after release outputs word(0).
REQ-025 Reset SHALL take priority over wBusy.

Verification
REQ-026 Reset: rst=0 for 5 cycles -> data_out=16'h0000 every cycle; release with wBusy=0 -> next edge outputs word(0).
REQ-027 Main path: wData=64'h0123_4567_89ab_cdef; slot s main_sel=s and origin=0 for all slots -> data_out cycles 16'hcdef, 16'h89ab, 16'h4567, 16'h0123, then repeats.
REQ-028 Reg path: wRegs0=32'hffffabef, wRegs7=32'haaaabbbb; slots 0..3 origin=1 with regs_sel=0..3 -> group 0 gives 16'habef; slots 12..15 with regs_sel=60..63 -> group 3 gives 16'haaaa.
REQ-029 Mixed origin: slots 0..3 origin=1 and slots 4..15 origin=0 with the main-path settings of REQ-027 -> words 16'habef, 16'h89ab, 16'h4567, 16'h0123.
REQ-030 Stall: hold wBusy=1 for 3 cycles at g=2 -> data_out frozen at word(1); after release the next edge outputs word(2).
REQ-031 Live update: change wRegs7 to 32'h23456789 mid-run with slots 12..15 regs_sel=60..63 -> the next group-3 word is 16'h2345.

Source files
------------

// File: rtl/data_selector.sv
// -----------------------------------------------------------------------------
// data_selector
//
// Purpose:
//   Picks nibble-sized items from either a main data word or a register bank
//   and serialises them onto a registered output word.  Selector slots are
//   grouped into SELECTOR_OUTPUTS_PER_BUS groups of SELECTOR_OUTPUTS slots.
//   A small rotating group counter chooses which group is resolved on each
//   unstalled clock edge.  The result of that group is registered onto
//   data_out, so an input change appears one clock later.
//
// Ports:
//   clk       - single clock; all state changes on its rising edge
//   rst       - synchronous, active-low reset; overrides wBusy
//   wBusy     - stall; when high, data_out and the group counter hold
//   wSelec    - one selector per slot, SLOT_W bits each, packed as
//               {regs_sel, main_sel, origin} with origin in the LSB
//   wData     - main items, item k = wData[k*DATA_WIDTH +: DATA_WIDTH]
//   wRegs0..7 - register bank {wRegs7, ..., wRegs0}; item 0 is wRegs0[3:0]
//   data_out  - registered result word; slot 0 of a group is in the LSBs
// -----------------------------------------------------------------------------
module data_selector #(
   parameter int DATA_WIDTH               = 4,
   parameter int MAIN_INPUTS              = 16,
   parameter int REGS_INPUTS              = 64,
   parameter int REGS_BITS_PER_INPUT      = 32,
   parameter int SELECTOR_OUTPUTS         = 4,
   parameter int SELECTOR_OUTPUTS_PER_BUS = 4,
   localparam int MSEL_W = $clog2(MAIN_INPUTS),
   localparam int RSEL_W = $clog2(REGS_INPUTS),
   localparam int SLOT_W = RSEL_W + MSEL_W + 1,
   localparam int SLOTS  = SELECTOR_OUTPUTS * SELECTOR_OUTPUTS_PER_BUS,
   localparam int OUT_W  = SELECTOR_OUTPUTS * DATA_WIDTH
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           wBusy,
   input  logic [SLOTS*SLOT_W-1:0]        wSelec,
   input  logic [MAIN_INPUTS*DATA_WIDTH-1:0] wData,
   input  logic [REGS_BITS_PER_INPUT-1:0] wRegs0,
   input  logic [REGS_BITS_PER_INPUT-1:0] wRegs1,
   input  logic [REGS_BITS_PER_INPUT-1:0] wRegs2,
   input  logic [REGS_BITS_PER_INPUT-1:0] wRegs3,
   input  logic [REGS_BITS_PER_INPUT-1:0] wRegs4,
   input  logic [REGS_BITS_PER_INPUT-1:0] wRegs5,
   input  logic [REGS_BITS_PER_INPUT-1:0] wRegs6,
   input  logic [REGS_BITS_PER_INPUT-1:0] wRegs7,
   output logic [OUT_W-1:0]               data_out
);

   // Group counter needs at least one bit even with a single group.
   localparam int GW = (SELECTOR_OUTPUTS_PER_BUS > 1) ? $clog2(SELECTOR_OUTPUTS_PER_BUS) : 1;
   localparam logic [GW-1:0] LAST_GROUP = GW'(SELECTOR_OUTPUTS_PER_BUS - 1);

   // ------------------------------------------------------------------
   // Item tables
   // ------------------------------------------------------------------
   logic [8*REGS_BITS_PER_INPUT-1:0] reg_bank;
   logic [DATA_WIDTH-1:0]            main_items [MAIN_INPUTS];
   logic [DATA_WIDTH-1:0]            reg_items  [REGS_INPUTS];

   assign reg_bank = {wRegs7, wRegs6, wRegs5, wRegs4, wRegs3, wRegs2, wRegs1, wRegs0};

   generate
      for (genvar gi = 0; gi < MAIN_INPUTS; gi++) begin : g_main_items
         assign main_items[gi] = wData[gi*DATA_WIDTH +: DATA_WIDTH];
      end
      for (genvar gi = 0; gi < REGS_INPUTS; gi++) begin : g_reg_items
         assign reg_items[gi] = reg_bank[gi*DATA_WIDTH +: DATA_WIDTH];
      end
   endgenerate

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic [GW-1:0]    group_reg;
   logic [GW-1:0]    group_next;
   logic [OUT_W-1:0] data_out_reg;
   logic [OUT_W-1:0] word_next;

   // Rotation wraps explicitly so non-power-of-two group counts also work.
   always_comb begin
      group_next = group_reg + 1'b1;
      if (group_reg == LAST_GROUP) begin
         group_next = '0;
      end
   end

   // ------------------------------------------------------------------
   // Per-lane resolution for the currently addressed group.  The slot
   // fields of the active group are picked first, then each lane muxes
   // between the main item and the register item; the unused select
   // field of a slot simply never reaches the output.
   // ------------------------------------------------------------------
   generate
      for (genvar gi = 0; gi < SELECTOR_OUTPUTS; gi++) begin : g_lane
         logic [SLOT_W-1:0]     slot_sel;
         logic                  origin;
         logic [MSEL_W-1:0]     main_sel;
         logic [RSEL_W-1:0]     regs_sel;
         logic [DATA_WIDTH-1:0] item;

         always_comb begin
            slot_sel = wSelec[(int'(group_reg) * SELECTOR_OUTPUTS + gi) * SLOT_W +: SLOT_W];
         end

         assign origin   = slot_sel[0];
         assign main_sel = slot_sel[MSEL_W:1];
         assign regs_sel = slot_sel[SLOT_W-1:MSEL_W+1];
         assign item     = origin ? reg_items[regs_sel] : main_items[main_sel];

         assign word_next[gi*DATA_WIDTH +: DATA_WIDTH] = item;
      end
   endgenerate

   // Reset wins over the stall; a stall freezes both the word and the rotation.
   always_ff @(posedge clk) begin
      if (!rst) begin
         data_out_reg <= '0;
         group_reg    <= '0;
      end else if (!wBusy) begin
         data_out_reg <= word_next;
         group_reg    <= group_next;
      end
   end

   assign data_out = data_out_reg;

endmodule

// File: tb/tb_data_selector.sv
// -----------------------------------------------------------------------------
// tb_data_selector
//
// Directed bench for data_selector at default parameters.  Inputs change one
// time unit after a rising edge and data_out is sampled one time unit after
// the next rising edge, so every check sees the word registered at that edge.
// -----------------------------------------------------------------------------
module tb_data_selector;

   logic         clk = 1'b0;
   logic         rst;
   logic         wBusy;
   logic [175:0] wSelec;
   logic [63:0]  wData;
   logic [31:0]  wRegs0, wRegs1, wRegs2, wRegs3, wRegs4, wRegs5, wRegs6, wRegs7;
   logic [15:0]  data_out;

   int checks_cnt = 0;
   int errors_cnt = 0;

   always #5 clk = ~clk;

   data_selector dut (
      .clk      (clk),
      .rst      (rst),
      .wBusy    (wBusy),
      .wSelec   (wSelec),
      .wData    (wData),
      .wRegs0   (wRegs0),
      .wRegs1   (wRegs1),
      .wRegs2   (wRegs2),
      .wRegs3   (wRegs3),
      .wRegs4   (wRegs4),
      .wRegs5   (wRegs5),
      .wRegs6   (wRegs6),
      .wRegs7   (wRegs7),
      .data_out (data_out)
   );

   task automatic check_value(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks_cnt++;
      if (obs !== exp) begin
         errors_cnt++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end else begin
         $display("ok   %s: %h", tag, obs);
      end
   endtask

   task automatic set_slot(input int s, input logic origin, input logic [3:0] msel, input logic [5:0] rsel);
      wSelec[s*11 +: 11] = {rsel, msel, origin};
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_expect(input string tag, input logic [15:0] exp);
      tick();
      check_value(tag, data_out, exp);
   endtask

   initial begin
      // Main-path setup: every slot reads main item s; regs_sel carries
      // junk that must be ignored while origin is 0.
      rst    = 1'b0;
      wBusy  = 1'b0;
      wSelec = '0;
      wData  = 64'h0123_4567_89ab_cdef;
      wRegs0 = 32'hffffabef;
      wRegs1 = 32'h13572468;
      wRegs2 = 32'h9bdf0ace;
      wRegs3 = 32'h11223344;
      wRegs4 = 32'h55667788;
      wRegs5 = 32'h99aabbcc;
      wRegs6 = 32'hddeeff00;
      wRegs7 = 32'haaaabbbb;
      for (int s = 0; s < 16; s++) set_slot(s, 1'b0, 4'(s), 6'(63 - s));

      // Reset holds the output at zero, also while stalled.
      for (int i = 0; i < 5; i++) begin
         wBusy = (i >= 3);
         run_expect($sformatf("reset_%0d", i), 16'h0000);
      end

      // Main path: two full rotations.
      rst   = 1'b1;
      wBusy = 1'b0;
      run_expect("main_g0", 16'hcdef);
      run_expect("main_g1", 16'h89ab);
      run_expect("main_g2", 16'h4567);
      run_expect("main_g3", 16'h0123);
      run_expect("main_g0_again", 16'hcdef);
      run_expect("main_g1_again", 16'h89ab);
      run_expect("main_g2_again", 16'h4567);
      run_expect("main_g3_again", 16'h0123);

      // Mixed origin: group 0 from the register bank, main_sel is junk there.
      for (int s = 0; s < 4; s++) set_slot(s, 1'b1, 4'(15 - s), 6'(s));
      run_expect("mixed_g0", 16'habef);
      run_expect("mixed_g1", 16'h89ab);
      run_expect("mixed_g2", 16'h4567);
      run_expect("mixed_g3", 16'h0123);

      // Reg path at the top of the bank: group 3 reads items 60..63.
      for (int s = 12; s < 16; s++) set_slot(s, 1'b1, 4'(s + 1), 6'(48 + s));
      run_expect("regs_g0", 16'habef);
      run_expect("regs_g1", 16'h89ab);
      run_expect("regs_g2", 16'h4567);
      run_expect("regs_g3", 16'haaaa);

      // Stall at g=2: output frozen at word(1) even though inputs change.
      run_expect("pre_stall_g0", 16'habef);
      run_expect("pre_stall_g1", 16'h89ab);
      wBusy = 1'b1;
      wData = 64'hfedc_ba98_7654_3210;
      for (int i = 0; i < 3; i++) begin
         run_expect($sformatf("stall_%0d", i), 16'h89ab);
      end
      wData = 64'h0123_4567_89ab_cdef;
      wBusy = 1'b0;
      run_expect("post_stall_g2", 16'h4567);
      run_expect("post_stall_g3", 16'haaaa);

      // Live update of wRegs7 shows up on the next group-3 word.
      wRegs7 = 32'h23456789;
      run_expect("live_g0", 16'habef);
      run_expect("live_g1", 16'h89ab);
      run_expect("live_g2", 16'h4567);
      run_expect("live_g3", 16'h2345);

      // Reset mid-rotation (while stalled) restarts at word(0).
      run_expect("mid_g0", 16'habef);
      run_expect("mid_g1", 16'h89ab);
      rst   = 1'b0;
      wBusy = 1'b1;
      run_expect("mid_reset", 16'h0000);
      rst   = 1'b1;
      wBusy = 1'b0;
      run_expect("after_reset_g0", 16'habef);
      run_expect("after_reset_g1", 16'h89ab);

      // Duplicates: all of group 0 selects main item 5.
      for (int s = 0; s < 4; s++) set_slot(s, 1'b0, 4'd5, 6'(s + 20));
      run_expect("dup_g2", 16'h4567);
      run_expect("dup_g3", 16'h2345);
      run_expect("dup_g0", 16'haaaa);

      $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
      $finish;
   end

endmodule
